// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: 2-entry in-order skid buffer with miss-stall counter.
// Optional operand forwarding from buffered entries is enabled by defining MEM_WB_FWD_EN.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              hit,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [REG_W-1:0]  write_reg,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_reg,
  output logic              wb_en,
`ifdef MEM_WB_FWD_EN
  input  logic [REG_W-1:0]  fwd_rs,
  input  logic [REG_W-1:0]  fwd_rt,
  output logic              fwd_rs_hit,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic [DATA_W-1:0] fwd_rt_data,
`endif
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  // The write-back value is resolved at capture, so entries only carry what WB needs.
  typedef struct packed {
    logic              reg_write;
    logic [REG_W-1:0]  write_reg;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t           r_state;
  logic             r_in_ready;
  entry_t           r_head;
  entry_t           r_tail;
  logic [CNT_W-1:0] r_stall_cnt;

  state_t w_state_nxt;
  entry_t w_head_nxt;
  entry_t w_tail_nxt;
  entry_t w_in_entry;
  logic   w_push;
  logic   w_pop;
  logic   w_miss;

  assign w_in_entry.reg_write = reg_write;
  assign w_in_entry.write_reg = write_reg;
  assign w_in_entry.data      = mem_to_reg ? read_data : alu_result;

  assign out_valid = (r_state != S_EMPTY);
  assign in_ready  = r_in_ready;
  assign w_push    = in_valid & r_in_ready & (hit | ~mem_to_reg) & ~flush;
  assign w_pop     = out_valid & out_ready;
  assign w_miss    = in_valid & r_in_ready & mem_to_reg & ~hit;

  // A reset cycle discards the head, so it must not reach the register file.
  assign wb_en     = w_pop & r_head.reg_write & (r_head.write_reg != '0) & ~rst;
  assign wb_data   = r_head.data;
  assign wb_reg    = r_head.write_reg;
  assign stall_cnt = r_stall_cnt;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    unique case (r_state)
      S_EMPTY: begin
        if (w_push) begin
          w_head_nxt  = w_in_entry;
          w_state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        unique case ({w_push, w_pop})
          2'b10: begin
            w_tail_nxt  = w_in_entry;
            w_state_nxt = S_TWO;
          end
          2'b01:   w_state_nxt = S_EMPTY;
          2'b11:   w_head_nxt  = w_in_entry;
          default: ;
        endcase
      end
      S_TWO: begin
        if (w_pop) begin
          w_head_nxt  = r_tail;
          w_state_nxt = S_ONE;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    if (flush) w_state_nxt = S_EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      // NOTE: entry storage is cleared on reset because wb_data/wb_reg expose the head directly.
      r_head      <= '0;
      r_tail      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != S_TWO);
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      if (w_miss && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

`ifdef MEM_WB_FWD_EN
  function automatic logic fwd_match(input entry_t e, input logic [REG_W-1:0] idx);
    return e.reg_write && (e.write_reg == idx) && (e.write_reg != '0);
  endfunction

  // The tail is the younger entry, so it takes priority when both match.
  always_comb begin
    fwd_rs_hit  = 1'b0;
    fwd_rs_data = '0;
    fwd_rt_hit  = 1'b0;
    fwd_rt_data = '0;
    if (r_state == S_TWO && fwd_match(r_tail, fwd_rs)) begin
      fwd_rs_hit  = 1'b1;
      fwd_rs_data = r_tail.data;
    end else if (r_state != S_EMPTY && fwd_match(r_head, fwd_rs)) begin
      fwd_rs_hit  = 1'b1;
      fwd_rs_data = r_head.data;
    end
    if (r_state == S_TWO && fwd_match(r_tail, fwd_rt)) begin
      fwd_rt_hit  = 1'b1;
      fwd_rt_data = r_tail.data;
    end else if (r_state != S_EMPTY && fwd_match(r_head, fwd_rt)) begin
      fwd_rt_hit  = 1'b1;
      fwd_rt_data = r_head.data;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table with a write-back scoreboard,
// plus hand-written sequences for counter saturation, mid-operation reset and forwarding.
module tb_mem_wb_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, hit, reg_write, mem_to_reg;
  logic              out_valid, out_ready, wb_en;
  logic [DATA_W-1:0] read_data, alu_result, wb_data;
  logic [REG_W-1:0]  write_reg, wb_reg;
  logic [CNT_W-1:0]  stall_cnt;
  logic [REG_W-1:0]  fwd_rs, fwd_rt;
  logic              fwd_rs_hit, fwd_rt_hit;
  logic [DATA_W-1:0] fwd_rs_data, fwd_rt_data;

  mem_wb_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .hit(hit), .read_data(read_data), .alu_result(alu_result), .write_reg(write_reg),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .out_valid(out_valid),
    .out_ready(out_ready), .wb_data(wb_data), .wb_reg(wb_reg), .wb_en(wb_en),
`ifdef MEM_WB_FWD_EN
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .fwd_rs_hit(fwd_rs_hit), .fwd_rt_hit(fwd_rt_hit),
    .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
`endif
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              iv, fl, ordy, m2r, hit, rw;
    logic [REG_W-1:0]  wr;
    logic [DATA_W-1:0] alu, rd;
    logic              e_ov, e_ir, e_wben;
    int                e_stall;   // -1: not checked at this vector
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  wreg;
    logic              en;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   m_stall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic fl, input logic ordy,
                              input logic m2r, input logic h, input logic rw,
                              input logic [REG_W-1:0] wr, input logic [DATA_W-1:0] alu,
                              input logic [DATA_W-1:0] rd, input logic e_ov,
                              input logic e_ir, input logic e_wben, input int e_stall);
    vec_t v;
    v.iv = iv; v.fl = fl; v.ordy = ordy; v.m2r = m2r; v.hit = h; v.rw = rw;
    v.wr = wr; v.alu = alu; v.rd = rd;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_wben = e_wben; v.e_stall = e_stall;
    return v;
  endfunction

  // Drive one cycle at posedge+1, check before the next edge, then advance the model.
  task automatic step(input vec_t v);
    int   occ;
    exp_t e;
    in_valid = v.iv; flush = v.fl; out_ready = v.ordy; mem_to_reg = v.m2r;
    hit = v.hit; reg_write = v.rw; write_reg = v.wr; alu_result = v.alu; read_data = v.rd;
    #1;
    check("out_valid", out_valid, v.e_ov);
    check("in_ready", in_ready, v.e_ir);
    check("wb_en", wb_en, v.e_wben);
    check("stall_cnt model", stall_cnt, m_stall);
    if (v.e_stall >= 0) check("stall_cnt table", stall_cnt, v.e_stall);
    occ = sb.size();
    if (occ > 0 && v.ordy) begin
      e = sb.pop_front();
      check("wb_data", wb_data, e.data);
      check("wb_reg", wb_reg, e.wreg);
      check("wb_en scoreboard", wb_en, e.en);
    end
    if (v.iv && occ < 2 && v.m2r && !v.hit && m_stall < CNT_MAX) m_stall++;
    if (v.iv && occ < 2 && (v.hit || !v.m2r) && !v.fl) begin
      e.data = v.m2r ? v.rd : v.alu;
      e.wreg = v.wr;
      e.en   = v.rw && (v.wr != 0);
      sb.push_back(e);
    end
    if (v.fl) sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // iv fl ordy m2r hit rw wr alu rd | ov ir wben stall
    // streaming: four ALU entries, one write-back per cycle
    vecs.push_back(mk(1,0,1,0,0,1,5'd1,32'd1,32'h0, 0,1,0,-1));
    vecs.push_back(mk(1,0,1,0,0,1,5'd2,32'd2,32'h0, 1,1,1,-1));
    vecs.push_back(mk(1,0,1,0,0,1,5'd3,32'd3,32'h0, 1,1,1,-1));
    vecs.push_back(mk(1,0,1,0,0,1,5'd4,32'd4,32'h0, 1,1,1,-1));
    vecs.push_back(mk(0,0,1,0,0,0,5'd0,32'd0,32'h0, 1,1,1,-1));
    vecs.push_back(mk(0,0,1,0,0,0,5'd0,32'd0,32'h0, 0,1,0, 0));
    // load miss for three cycles, then hit
    vecs.push_back(mk(1,0,1,1,0,1,5'd5,32'h1234,32'h0, 0,1,0,0));
    vecs.push_back(mk(1,0,1,1,0,1,5'd5,32'h1234,32'h0, 0,1,0,1));
    vecs.push_back(mk(1,0,1,1,0,1,5'd5,32'h1234,32'h0, 0,1,0,2));
    vecs.push_back(mk(1,0,1,1,1,1,5'd5,32'h1234,32'hDEADBEEF, 0,1,0,3));
    vecs.push_back(mk(0,0,1,0,0,0,5'd0,32'd0,32'h0, 1,1,1,3));
    vecs.push_back(mk(0,0,1,0,0,0,5'd0,32'd0,32'h0, 0,1,0,3));
    // backpressure: third entry held upstream, then in-order drain
    vecs.push_back(mk(1,0,0,0,0,1,5'd1,32'h11,32'h0, 0,1,0,-1));
    vecs.push_back(mk(1,0,0,0,0,1,5'd2,32'h12,32'h0, 1,1,0,-1));
    vecs.push_back(mk(1,0,0,0,0,1,5'd3,32'h13,32'h0, 1,0,0,-1));
    vecs.push_back(mk(1,0,1,0,0,1,5'd3,32'h13,32'h0, 1,0,1,-1));
    vecs.push_back(mk(1,0,1,0,0,1,5'd3,32'h13,32'h0, 1,1,1,-1));
    vecs.push_back(mk(0,0,1,0,0,0,5'd0,32'd0,32'h0, 1,1,1,-1));
    vecs.push_back(mk(0,0,1,0,0,0,5'd0,32'd0,32'h0, 0,1,0,-1));
    // flush in TWO with an incoming entry
    vecs.push_back(mk(1,0,0,0,0,1,5'd8,32'h21,32'h0, 0,1,0,-1));
    vecs.push_back(mk(1,0,0,0,0,1,5'd9,32'h22,32'h0, 1,1,0,-1));
    vecs.push_back(mk(1,1,0,0,0,1,5'd10,32'h23,32'h0, 1,0,0,-1));
    vecs.push_back(mk(0,0,0,0,0,0,5'd0,32'd0,32'h0, 0,1,0,-1));
    // flush in ONE with a same-cycle pop: pop still writes back, push is dropped
    vecs.push_back(mk(1,0,0,0,0,1,5'd10,32'h31,32'h0, 0,1,0,-1));
    vecs.push_back(mk(1,1,1,0,0,1,5'd11,32'h32,32'h0, 1,1,1,-1));
    vecs.push_back(mk(0,0,1,0,0,0,5'd0,32'd0,32'h0, 0,1,0,-1));
    // a miss during flush is still counted
    vecs.push_back(mk(1,1,1,1,0,1,5'd6,32'd0,32'h0, 0,1,0,3));
    vecs.push_back(mk(0,0,1,0,0,0,5'd0,32'd0,32'h0, 0,1,0,4));
    // register zero and reg_write=0: popped without write strobe
    vecs.push_back(mk(1,0,1,0,0,1,5'd0,32'h55,32'h0, 0,1,0,-1));
    vecs.push_back(mk(1,0,1,0,0,0,5'd3,32'h66,32'h0, 1,1,0,-1));
    vecs.push_back(mk(0,0,1,0,0,0,5'd0,32'd0,32'h0, 1,1,0,-1));
    vecs.push_back(mk(0,0,1,0,0,0,5'd0,32'd0,32'h0, 0,1,0,-1));

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; hit = 1'b0; read_data = '0; alu_result = '0;
    write_reg = '0; reg_write = 1'b0; mem_to_reg = 1'b0; out_ready = 1'b1;
    fwd_rs = '0; fwd_rt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset stall_cnt", stall_cnt, 0);
    check("reset wb_data", wb_data, 0);
    check("reset wb_reg", wb_reg, 0);
    check("reset wb_en", wb_en, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // stall counter saturation
    for (int i = 0; i < CNT_MAX; i++) step(mk(1,0,1,1,0,1,5'd6,32'd0,32'h0, 0,1,0,-1));
    step(mk(0,0,1,0,0,0,5'd0,32'd0,32'h0, 0,1,0,CNT_MAX));

    // reset while full: entries lost, no write strobe
    step(mk(1,0,0,0,0,1,5'd4,32'h77,32'h0, 0,1,0,-1));
    step(mk(1,0,0,0,0,1,5'd5,32'h78,32'h0, 1,1,0,-1));
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    #1;
    check("rst wb_en gated", wb_en, 0);
    check("rst out_valid before edge", out_valid, 1);
    @(posedge clk);
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 1);
    check("rst stall_cnt", stall_cnt, 0);
    check("rst wb_data", wb_data, 0);
    check("rst wb_reg", wb_reg, 0);
    sb.delete();
    m_stall = 0;
    rst = 1'b0; flush = 1'b0;
    step(mk(0,0,1,0,0,0,5'd0,32'd0,32'h0, 0,1,0,0));

`ifdef MEM_WB_FWD_EN
    step(mk(1,0,0,0,0,1,5'd7,32'h10,32'h0, 0,1,0,-1));
    step(mk(1,0,0,0,0,1,5'd7,32'h20,32'h0, 1,1,0,-1));
    in_valid = 1'b0; fwd_rs = 5'd7; fwd_rt = 5'd3;
    #1;
    check("fwd_rs_hit", fwd_rs_hit, 1);
    check("fwd_rs_data", fwd_rs_data, 32'h20);
    check("fwd_rt_hit", fwd_rt_hit, 0);
    check("fwd_rt_data", fwd_rt_data, 0);
    step(mk(0,0,1,0,0,0,5'd0,32'd0,32'h0, 1,0,1,-1));
    #1;
    check("fwd_rs_data one entry", fwd_rs_data, 32'h20);
    step(mk(0,0,1,0,0,0,5'd0,32'd0,32'h0, 1,1,1,-1));
    #1;
    check("fwd_rs_hit empty", fwd_rs_hit, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
